reg_manager: RTL
================

REG_MANAGER -- requirements
Module: reg_manager

Interface
REQ-001 SHALL have parameter LEN_VREG_ADDR, default 5, virtual register address width (32 vregs).
REQ-002 SHALL have parameter LEN_PREG_ADDR, default 6, physical register address width (64 pregs).
REQ-003 SHALL have parameter LEN_WORD, default 32, data word width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports rs1_order, rs2_order  input  1 each  source lookup requested.
REQ-007 SHALL have ports va_rs1, va_rs2  input  LEN_VREG_ADDR each  source vreg.
REQ-008 SHALL have port rd_order  input  1  destination rename requested.
REQ-009 SHALL have port va_rd  input  LEN_VREG_ADDR  destination vreg.
REQ-010 SHALL have ports rs1_ready, rs2_ready  output  1 each  source value valid.
REQ-011 SHALL have ports d_rs1, d_rs2  output  LEN_WORD each  source value.
REQ-012 SHALL have port rd_ready  output  1  destination preg granted this cycle.
REQ-013 SHALL have port pa_rd  output  LEN_PREG_ADDR  granted destination preg.
REQ-014 SHALL have ports wb_valid 1, wb_preg LEN_PREG_ADDR, wb_data LEN_WORD  inputs  execution writeback.
REQ-015 SHALL have ports rel_valid 1, rel_preg LEN_PREG_ADDR  inputs  retired preg returned to free list.
REQ-016 SHALL have port free_count  output  LEN_PREG_ADDR  number of entries in free list.

Function
REQ-017 SHALL hold map table (32 x preg), physical file (64 x word), per-preg valid bit, free-list FIFO depth 32 with head, tail, count.
REQ-018 Responses (REQ-010..013) SHALL be combinational from current state and same-cycle inputs; state changes only at clk edge.
REQ-019 Order low SHALL give ready=1, data=0 for rs, and rd_ready=0, pa_rd=0 for rd.
REQ-020 rs lookup: p=map[va]; ready=valid[p], data=prf[p] when ready, else data=0.
REQ-021 Bypass: wb_valid with wb_preg==p and p!=0 SHALL give ready=1, data=wb_data same cycle.
REQ-022 va==0 SHALL always give ready=1, data=0; preg 0 hardwired zero, always valid, never in free list.
REQ-023 rd with va_rd!=0 and count>0 SHALL give rd_ready=1, pa_rd=free-list head; at edge map[va_rd]<=head, valid[head]<=0, pop.
REQ-024 rd with count==0 SHALL give rd_ready=0, pa_rd=0, no state change; same-cycle release SHALL NOT bypass into allocation.
REQ-025 rd with va_rd==0 SHALL give rd_ready=1, pa_rd=0, no allocation.
REQ-026 Rename in same cycle as lookup of same vreg: rs SHALL see the pre-rename mapping.
REQ-027 Writeback SHALL set prf[wb_preg]<=wb_data, valid<=1 at edge; wb_preg==0 ignored.
REQ-028 Writeback to preg allocated in same cycle: allocation's valid<=0 SHALL win.
REQ-029 Release SHALL push rel_preg at tail; ignored when rel_preg==0 or count==32.
REQ-030 Simultaneous pop and push SHALL leave count unchanged; head and tail wrap modulo 32.
REQ-031 free_count SHALL equal count, registered state.

Reset
REQ-032 On rstn low, immediately: map[v]=v for v 0..31, all valid=1, prf all zero, free list = pregs 32..63 in ascending order from head, count=32, head=tail=0.
REQ-033 During reset outputs SHALL follow REQ-018 from reset state; no writeback/release/rename takes effect until rstn high.
REQ-034 Reset asserted mid-operation SHALL discard all renames, pending values and releases.

Verification
REQ-035 After reset, rs1 va=5 -> rs1_ready=1, d_rs1=0; free_count=32.
REQ-036 rd va=3 -> rd_ready=1, pa_rd=32; next cycle rs1 va=3 -> rs1_ready=0; wb preg 32 data 0xDEADBEEF -> same cycle rs1_ready=1, d_rs1=0xDEADBEEF; next cycle same from prf.
REQ-037 Same cycle rs1 va=4, rd va=4 -> rs1 reads preg 4 (ready=1); subsequent lookup va=4 reads preg 32.
REQ-038 32 renames to va=1 -> free_count=0; 33rd rd_ready=0, pa_rd=0; release preg 7 -> free_count=1; next rd gets pa_rd=7.
REQ-039 rd va=0 -> rd_ready=1, pa_rd=0, free_count unchanged; wb preg 0 data 5 -> lookup va=0 still 0.
REQ-040 Rename va=2 then assert rstn low mid-stream -> map[2]=2, free_count=32, head preg 32 restored.

Source files
------------

// File: rtl/reg_manager.sv
// reg_manager: register renaming unit.
// Holds the vreg->preg map table, the physical register file with a
// per-preg valid bit, and a circular free list of unallocated pregs.
// Lookups and grants are combinational from the current state and
// the same-cycle inputs. All state changes on the rising clock edge.
// The free-list depth is NUM_PREG - NUM_VREG. It must be a power of two
// so that the head and tail pointers wrap by plain overflow.
module reg_manager #(
    parameter int LEN_VREG_ADDR = 5,
    parameter int LEN_PREG_ADDR = 6,
    parameter int LEN_WORD      = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rs1_order,
    input  logic                     rs2_order,
    input  logic [LEN_VREG_ADDR-1:0] va_rs1,
    input  logic [LEN_VREG_ADDR-1:0] va_rs2,
    input  logic                     rd_order,
    input  logic [LEN_VREG_ADDR-1:0] va_rd,
    output logic                     rs1_ready,
    output logic                     rs2_ready,
    output logic [LEN_WORD-1:0]      d_rs1,
    output logic [LEN_WORD-1:0]      d_rs2,
    output logic                     rd_ready,
    output logic [LEN_PREG_ADDR-1:0] pa_rd,
    input  logic                     wb_valid,
    input  logic [LEN_PREG_ADDR-1:0] wb_preg,
    input  logic [LEN_WORD-1:0]      wb_data,
    input  logic                     rel_valid,
    input  logic [LEN_PREG_ADDR-1:0] rel_preg,
    output logic [LEN_PREG_ADDR-1:0] free_count
);

    localparam int NUM_VREG = 1 << LEN_VREG_ADDR;
    localparam int NUM_PREG = 1 << LEN_PREG_ADDR;
    localparam int FL_DEPTH = NUM_PREG - NUM_VREG;
    localparam int FL_AW    = $clog2(FL_DEPTH);
    localparam logic [FL_AW:0] FL_FULL = (FL_AW + 1)'(FL_DEPTH);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [LEN_PREG_ADDR-1:0] map_q [NUM_VREG];
    logic [LEN_WORD-1:0]      prf_q [NUM_PREG];
    logic [NUM_PREG-1:0]      valid_q;
    logic [LEN_PREG_ADDR-1:0] fl_q  [FL_DEPTH];
    logic [FL_AW-1:0]         head_q;
    logic [FL_AW-1:0]         tail_q;
    logic [FL_AW:0]           count_q;

    // ---------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------
    logic                     fl_empty;
    logic                     fl_full;
    logic                     alloc;
    logic                     push;
    logic                     wb_en;
    logic [LEN_PREG_ADDR-1:0] head_preg;

    assign fl_empty  = (count_q == '0);
    assign fl_full   = (count_q == FL_FULL);
    assign head_preg = fl_q[head_q];
    // A release never feeds an allocation in the same cycle. alloc looks
    // only at the registered count.
    assign alloc     = rd_order && (va_rd != '0) && !fl_empty;
    assign push      = rel_valid && (rel_preg != '0) && !fl_full;
    assign wb_en     = wb_valid && (wb_preg != '0);

    // ---------------------------------------------------------------
    // Source lookups: one identical slice per read port
    // ---------------------------------------------------------------
    logic [1:0]                     rs_order;
    logic [1:0][LEN_VREG_ADDR-1:0]  rs_va;
    logic [1:0]                     rs_rdy;
    logic [1:0][LEN_WORD-1:0]       rs_dat;

    assign rs_order = {rs2_order, rs1_order};
    assign rs_va    = {va_rs2, va_rs1};

    for (genvar i = 0; i < 2; i++) begin : g_rs
        logic [LEN_PREG_ADDR-1:0] p;
        // The lookup uses the map before any same-cycle rename.
        assign p = map_q[rs_va[i]];

        // Resolve readiness and data: writeback bypass first, then the file.
        always_comb begin
            rs_rdy[i] = 1'b1;
            rs_dat[i] = '0;
            if (rs_order[i] && (rs_va[i] != '0)) begin
                if (wb_valid && (wb_preg == p) && (p != '0)) begin
                    rs_dat[i] = wb_data;
                end else if (valid_q[p]) begin
                    rs_dat[i] = prf_q[p];
                end else begin
                    rs_rdy[i] = 1'b0;
                end
            end
        end
    end

    assign rs1_ready = rs_rdy[0];
    assign rs2_ready = rs_rdy[1];
    assign d_rs1     = rs_dat[0];
    assign d_rs2     = rs_dat[1];

    // ---------------------------------------------------------------
    // Destination grant
    // ---------------------------------------------------------------
    // vreg 0 is always granted with preg 0. Other vregs need a free entry.
    always_comb begin
        rd_ready = 1'b0;
        pa_rd    = '0;
        if (rd_order) begin
            if (va_rd == '0) begin
                rd_ready = 1'b1;
            end else if (!fl_empty) begin
                rd_ready = 1'b1;
                pa_rd    = head_preg;
            end
        end
    end

    assign free_count = LEN_PREG_ADDR'(count_q);

    // ---------------------------------------------------------------
    // Sequential updates
    // ---------------------------------------------------------------
    // Map table: reset to identity, retarget the renamed vreg on allocation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < NUM_VREG; v++) begin
                map_q[v] <= LEN_PREG_ADDR'(v);
            end
        end else if (alloc) begin
            map_q[va_rd] <= head_preg;
        end
    end

    // Register file and valid bits. The allocation clear comes last, so it
    // wins over a writeback to the same preg in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < NUM_PREG; p++) begin
                prf_q[p] <= '0;
            end
            valid_q <= '1;
        end else begin
            if (wb_en) begin
                prf_q[wb_preg]   <= wb_data;
                valid_q[wb_preg] <= 1'b1;
            end
            if (alloc) begin
                valid_q[head_preg] <= 1'b0;
            end
        end
    end

    // Free list FIFO: pop at head on allocation, push at tail on release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= LEN_PREG_ADDR'(NUM_VREG + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FL_FULL;
        end else begin
            if (alloc) begin
                head_q <= head_q + 1'b1;
            end
            if (push) begin
                fl_q[tail_q] <= rel_preg;
                tail_q       <= tail_q + 1'b1;
            end
            case ({alloc, push})
                2'b10:   count_q <= count_q - 1'b1;
                2'b01:   count_q <= count_q + 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
